// File: rtl/nlprg16_pkg.sv
// nlprg16_pkg: shared constants and state encoding for the nlprg16 stream checker.
package nlprg16_pkg;
    localparam int NLP_N          = 16;
    localparam int LOCK_CNT_DEF   = 4;
    localparam int UNLOCK_CNT_DEF = 3;
    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;
endpackage

// File: rtl/nlprg16_next.sv
// nlprg16_next: nlprg16 next-state function, a maximal 16-bit LFSR with the all-zero word spliced in.
module nlprg16_next
    import nlprg16_pkg::*;
(
    input  logic [NLP_N-1:0] x,
    output logic [NLP_N-1:0] y
);
    // Zero-detect on the kept bits turns 8000 -> 0000 -> 0001, giving a 2^16 cycle.
    assign y = {x[NLP_N-2:0], x[15] ^ x[13] ^ x[12] ^ x[10] ^ (x[NLP_N-2:0] == '0)};
endmodule

// File: rtl/nlprg16_chk.sv
// nlprg16_chk: locks onto an nlprg16 word stream, flags locked mismatches and measures the zero-to-zero period.
module nlprg16_chk
    import nlprg16_pkg::*;
#(
    parameter int N          = NLP_N,
    parameter int LOCK_CNT   = LOCK_CNT_DEF,
    parameter int UNLOCK_CNT = UNLOCK_CNT_DEF
) (
    input  logic          ck,
    input  logic          rst_n,
    input  logic          vld,
    input  logic [N-1:0]  d,
    output logic          lock,
    output logic          err,
    output logic [15:0]   err_cnt,
    output logic          per_vld,
    output logic [N:0]    period
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);
    state_t state, nxt_state;
    logic [N-1:0] pred, f_d, f_pred;
    logic [MW-1:0] match;
    logic [UW-1:0] miss;
    logic [N:0] pcnt;
    logic seen_zero, hit, lock_now, drop;
    nlprg16_next u_f_d    (.x(d),    .y(f_d));
    nlprg16_next u_f_pred (.x(pred), .y(f_pred));
    assign hit      = d == pred;
    assign lock_now = state == SYNC && hit && match == MW'(LOCK_CNT - 1);
    assign drop     = state == LOCKED && !hit && miss == UW'(UNLOCK_CNT - 1);
    always_ff @(posedge ck or negedge rst_n)
        if (!rst_n) state <= HUNT;
        else if (vld) state <= nxt_state;
    always_comb
        nxt_state = state == HUNT ? SYNC : lock_now ? LOCKED : drop ? HUNT : state;
    always_comb
        lock = state == LOCKED;
    // Once locked the predictor free-runs (flywheel) so isolated bad words cannot pull it off.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            pred      <= '0;
            match     <= '0;
            miss      <= '0;
            pcnt      <= '0;
            seen_zero <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            per_vld   <= 1'b0;
            period    <= '0;
        end else begin
            err     <= vld && state == LOCKED && !hit;
            per_vld <= vld && state == LOCKED && hit && d == '0 && seen_zero;
            if (vld) begin
                pred  <= state == LOCKED ? f_pred : f_d;
                match <= state == SYNC && hit ? match + 1'b1 : '0;
                miss  <= state == LOCKED && !hit ? miss + 1'b1 : '0;
                if (lock_now) begin
                    pcnt      <= (N+1)'(1);
                    seen_zero <= 1'b0;
                end else if (state == LOCKED) begin
                    if (hit && d == '0) begin
                        pcnt      <= (N+1)'(1);
                        seen_zero <= 1'b1;
                        if (seen_zero) period <= pcnt;
                    end else if (pcnt != '1) begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                if (state == LOCKED && !hit && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_nlprg16_chk.sv
// tb_nlprg16_chk: randomized self-checking bench for nlprg16_chk against a behavioural reference model.
module tb_nlprg16_chk;
    localparam int LOCKN = 4, UNLOCKN = 3;
    localparam int HU = 0, SY = 1, LK = 2;
    logic ck = 0, rst_n = 0, vld = 0;
    logic [15:0] d = '0;
    logic lock, err, per_vld;
    logic [15:0] err_cnt;
    logic [16:0] period;
    int checks = 0, failures = 0;
    int m_mode, m_match, m_miss, m_pcnt, m_cnt, m_period;
    logic [15:0] m_pred, g;
    bit m_seen, m_lock, m_err, m_pv;

    nlprg16_chk dut (.ck(ck), .rst_n(rst_n), .vld(vld), .d(d), .lock(lock), .err(err),
                     .err_cnt(err_cnt), .per_vld(per_vld), .period(period));

    always #5 ck = ~ck;

    // Generator defined by its orbit: maximal LFSR step, except 8000 -> 0000 -> 0001.
    function automatic logic [15:0] f_ref(input logic [15:0] x);
        if (x == 16'h8000) return 16'h0000;
        if (x == 16'h0000) return 16'h0001;
        return {x[14:0], ^(x & 16'hB400)};
    endfunction

    function automatic logic [15:0] before_zero(input int k);
        logic [15:0] s = 16'h0000;
        for (int i = 0; i < 65536 - k; i++) s = f_ref(s);
        return s;
    endfunction

    task automatic model_reset();
        m_mode = HU; m_match = 0; m_miss = 0; m_pcnt = 0; m_cnt = 0; m_period = 0;
        m_pred = '0; m_seen = 0; m_lock = 0; m_err = 0; m_pv = 0;
    endtask

    task automatic model_step(input logic v, input logic [15:0] w);
        m_err = 0; m_pv = 0;
        if (v) begin
            if (m_mode == LK) begin
                m_err = w != m_pred;
                m_pv  = w == m_pred && w == 0 && m_seen;
                if (w == m_pred && w == 0) begin
                    if (m_seen) m_period = m_pcnt;
                    m_pcnt = 1; m_seen = 1;
                end else if (m_pcnt < 131071) m_pcnt++;
                if (w == m_pred) m_miss = 0;
                else begin
                    m_miss++;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_miss == UNLOCKN) m_mode = HU;
                end
                m_pred = f_ref(m_pred);
            end else if (m_mode == SY && w == m_pred) begin
                m_pred = f_ref(w);
                m_match++;
                if (m_match == LOCKN) begin m_mode = LK; m_pcnt = 1; m_seen = 0; m_miss = 0; end
            end else begin
                m_pred = f_ref(w); m_match = 0; m_mode = SY;
            end
        end
        m_lock = m_mode == LK;
    endtask

    task automatic step(input logic v, input logic [15:0] w);
        vld = v; d = w;
        @(posedge ck); #1;
        model_step(v, w);
    endtask

    task automatic apply_reset();
        rst_n = 0;
        #2;
        model_reset();
        @(posedge ck); #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({lock, err, per_vld, err_cnt, period} !== 36'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {lock, err, per_vld, err_cnt, period});
        end
    endtask

    task automatic test_lock_timing();
        apply_reset();
        g = 16'($urandom);
        for (int k = 1; k <= 8; k++) begin
            step(1, g); g = f_ref(g);
            checks++;
            if (lock !== (k >= 5) || err !== 0 || {lock, err, per_vld, err_cnt, period} !== {m_lock, m_err, m_pv, 16'(m_cnt), 17'(m_period)}) begin
                failures++;
                $display("FAIL lock_timing word=%0d got lock=%0b err=%0b exp lock=%0b err=0", k, lock, err, k >= 5);
            end
        end
    endtask

    task automatic test_period();
        int npv = 0;
        apply_reset();
        g = before_zero(8);
        for (int k = 1; k <= 65548; k++) begin
            step(1, g); g = f_ref(g);
            if (per_vld) npv++;
            checks++;
            if ({lock, err, per_vld, err_cnt, period} !== {m_lock, m_err, m_pv, 16'(m_cnt), 17'(m_period)}) begin
                failures++;
                $display("FAIL period_model word=%0d got=%h exp=%h", k, {lock, err, per_vld, err_cnt, period},
                         {m_lock, m_err, m_pv, 16'(m_cnt), 17'(m_period)});
            end
        end
        checks++;
        if (npv != 1 || period !== 17'd65536 || err_cnt !== 16'd0) begin
            failures++;
            $display("FAIL period_full got pulses=%0d period=%0d err_cnt=%0d exp 1/65536/0", npv, period, err_cnt);
        end
    endtask

    task automatic test_single_flip();
        step(1, g ^ 16'h0001); g = f_ref(g);
        checks++;
        if (err !== 1 || err_cnt !== 16'd1 || lock !== 1) begin
            failures++;
            $display("FAIL single_flip got err=%0b cnt=%0d lock=%0b exp 1/1/1", err, err_cnt, lock);
        end
        step(1, g); g = f_ref(g);
        checks++;
        if (err !== 0 || err_cnt !== 16'd1 || lock !== 1) begin
            failures++;
            $display("FAIL flip_recover got err=%0b cnt=%0d lock=%0b exp 0/1/1", err, err_cnt, lock);
        end
    endtask

    task automatic test_unlock_relock();
        int base = m_cnt;
        for (int k = 1; k <= 3; k++) begin
            step(1, g ^ 16'(($urandom % 65535) + 1)); g = f_ref(g);
            checks++;
            if (err !== 1 || err_cnt !== 16'(base + k) || lock !== (k < 3)) begin
                failures++;
                $display("FAIL unlock word=%0d got err=%0b cnt=%0d lock=%0b exp 1/%0d/%0b", k, err, err_cnt, lock, base + k, k < 3);
            end
        end
        for (int k = 1; k <= 6; k++) begin
            step(1, g); g = f_ref(g);
            checks++;
            if (lock !== (k >= 5) || err !== 0 || err_cnt !== 16'(base + 3)) begin
                failures++;
                $display("FAIL relock word=%0d got lock=%0b err=%0b cnt=%0d exp %0b/0/%0d", k, lock, err, err_cnt, k >= 5, base + 3);
            end
        end
    endtask

    task automatic test_vld_toggle();
        apply_reset();
        g = before_zero(8);
        for (int k = 1; k <= 40; k++) begin
            step(1, g); g = f_ref(g);
            checks++;
            if (lock !== (k >= 5) || {lock, err, per_vld, err_cnt, period} !== {m_lock, m_err, m_pv, 16'(m_cnt), 17'(m_period)}) begin
                failures++;
                $display("FAIL toggle_vld word=%0d got=%h exp lock=%0b", k, {lock, err, per_vld, err_cnt, period}, k >= 5);
            end
            step(0, 16'($urandom));
            checks++;
            if (err !== 0 || per_vld !== 0 || lock !== (k >= 5)) begin
                failures++;
                $display("FAIL toggle_idle word=%0d got err=%0b pv=%0b lock=%0b exp 0/0/%0b", k, err, per_vld, lock, k >= 5);
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(1, ~g); g = f_ref(g);
        checks++;
        if (err !== 1 || err_cnt !== 16'd1 || lock !== 1) begin
            failures++;
            $display("FAIL pre_reset got err=%0b cnt=%0d lock=%0b exp 1/1/1", err, err_cnt, lock);
        end
        vld = 1; d = g;
        rst_n = 0;
        #1;
        checks++;
        if ({lock, err, per_vld, err_cnt, period} !== 36'd0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", {lock, err, per_vld, err_cnt, period});
        end
        model_reset();
        @(posedge ck); #1;
        rst_n = 1;
        g = f_ref(g);
        for (int k = 1; k <= 6; k++) begin
            step(1, g); g = f_ref(g);
            checks++;
            if (lock !== (k >= 5) || err !== 0 || err_cnt !== 16'd0) begin
                failures++;
                $display("FAIL reset_relock word=%0d got lock=%0b err=%0b cnt=%0d exp %0b/0/0", k, lock, err, err_cnt, k >= 5);
            end
        end
    endtask

    task automatic test_random();
        logic v;
        logic [15:0] w;
        apply_reset();
        g = 16'($urandom);
        for (int k = 0; k < 3000; k++) begin
            v = ($urandom % 4) != 0;
            w = ($urandom % 8) == 0 ? g ^ 16'(($urandom % 65535) + 1) : g;
            if (!v) w = 16'($urandom);
            step(v, w);
            if (v) g = f_ref(g);
            checks++;
            if ({lock, err, per_vld, err_cnt, period} !== {m_lock, m_err, m_pv, 16'(m_cnt), 17'(m_period)}) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", k, {lock, err, per_vld, err_cnt, period},
                         {m_lock, m_err, m_pv, 16'(m_cnt), 17'(m_period)});
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_lock_timing();
        test_period();
        test_single_flip();
        test_unlock_relock();
        test_vld_toggle();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
